// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for the divide corner cases.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [5:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [5:0]      rd_out,
    output logic            reg_write
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [6:0]      LAST = 7'(XLEN - 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_d;

    logic [6:0]      cnt;
    logic [XLEN-1:0] acc, x, y;
    logic            is_mul, is_rem, neg_q, neg_r;

    logic            in_mul, in_div, in_sgn, in_rem, in_ok;
    logic            div_zero, ovf, fast;
    logic [XLEN-1:0] fast_res, a_abs, b_abs;

    logic [XLEN:0]   sh, diff;
    logic [XLEN-1:0] acc_n, x_n, y_n, fin;
    logic            qbit;

    assign in_mul   = funct3 == 3'b000;
    assign in_div   = funct3[2];
    assign in_sgn   = funct3[2] & ~funct3[0];
    assign in_rem   = funct3[1];
    assign in_ok    = in_mul | in_div;
    assign div_zero = in_div && op_b == '0;
    assign ovf      = in_sgn && op_a == MINV && op_b == '1;

    assign a_abs = (in_sgn && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_abs = (in_sgn && op_b[XLEN-1]) ? -op_b : op_b;

    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        unique case (1'b1)
            !in_ok: begin
                fast     = 1'b1;
                fast_res = '0;
            end
            div_zero: begin
                fast     = 1'b1;
                fast_res = in_rem ? op_a : '1;
            end
            ovf: begin
                fast     = 1'b1;
                fast_res = in_rem ? '0 : op_a;
            end
            default: ;
        endcase
    end

    // One iteration: acc is the product/remainder, x the multiplicand/quotient,
    // y the multiplier/divisor.
    always_comb begin
        sh    = {acc, x[XLEN-1]};
        diff  = sh - {1'b0, y};
        qbit  = 1'b0;
        acc_n = acc;
        x_n   = x;
        y_n   = y;
        if (is_mul) begin
            acc_n = acc + (y[0] ? x : '0);
            x_n   = x << 1;
            y_n   = y >> 1;
        end else begin
            qbit  = ~diff[XLEN];
            acc_n = qbit ? diff[XLEN-1:0] : sh[XLEN-1:0];
            x_n   = {x[XLEN-2:0], qbit};
        end
    end

    always_comb begin
        fin = acc_n;
        if (!is_mul) begin
            if (is_rem)
                fin = neg_r ? -acc_n : acc_n;
            else
                fin = neg_q ? -x_n : x_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = fast ? DONE : RUN;
            RUN:  if (cnt == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            is_mul <= 1'b0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    acc    <= '0;
                    rd_out <= rd_in;
                    is_mul <= in_mul;
                    is_rem <= in_rem;
                    neg_q  <= in_sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                    neg_r  <= in_sgn & op_a[XLEN-1];
                    x      <= in_mul ? op_a : a_abs;
                    y      <= in_mul ? op_b : b_abs;
                    if (fast) result <= fast_res;
                end
                RUN: begin
                    acc <= acc_n;
                    x   <= x_n;
                    y   <= y_n;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        result <= fin;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign reg_write = done && rd_out != '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and busy/reset corner sequences.
module tb_muldiv_unit;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic [5:0]  rd_in;
    logic        busy, done, reg_write;
    logic [63:0] result;
    logic [5:0]  rd_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  rd;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy),
        .done(done), .result(result), .rd_out(rd_out),
        .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [63:0] sa, sb, sq;
        logic ov;
        sa = a;
        sb = b;
        ov = (a == MINV) && (b == ONES);
        case (f)
            3'b000: return a * b;
            3'b100: begin
                if (b == 0) return ONES;
                if (ov) return a;
                sq = sa / sb;
                return sq;
            end
            3'b101: return (b == 0) ? ONES : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ov) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            3'b111: return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        if (f inside {3'b001, 3'b010, 3'b011}) return 0;
        if (f[2] && b == 0) return 0;
        if ((f == 3'b100 || f == 3'b110) && a == MINV && b == ONES) return 0;
        return 64;
    endfunction

    // Issue one op from an idle unit and check latency, outputs and the
    // return to idle.
    task automatic run_op(input string name, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] rd, input logic [63:0] er,
                          input int lat);
        int k;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk({name, " busy"}, 64'(busy), 64'd1);
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles", name, k);
            return;
        end
        chk({name, " lat"}, 64'(k), 64'(lat));
        chk({name, " result"}, result, er);
        chk({name, " rd"}, 64'(rd_out), 64'(rd));
        chk({name, " wr"}, 64'(reg_write), 64'(rd != 0));
        tick();
        chk({name, " done_low"}, {62'd0, done, busy}, 64'd0);
        chk({name, " wr_low"}, 64'(reg_write), 64'd0);
        chk({name, " hold"}, result, er);
    endtask

    initial begin
        logic [2:0]  f;
        logic [63:0] a, b;
        logic [5:0]  rd;
        int seen;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset wr", 64'(reg_write), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset rd", 64'(rd_out), 64'd0);

        tbl.push_back('{3'b000, 64'd7, -64'sd3, 6'd5, 64'hFFFF_FFFF_FFFF_FFEB, 64});
        tbl.push_back('{3'b100, -64'sd20, 64'd3, 6'd1, 64'hFFFF_FFFF_FFFF_FFFA, 64});
        tbl.push_back('{3'b110, -64'sd20, 64'd3, 6'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64});
        tbl.push_back('{3'b100, 64'd20, -64'sd3, 6'd4, 64'hFFFF_FFFF_FFFF_FFFA, 64});
        tbl.push_back('{3'b110, 64'd20, -64'sd3, 6'd4, 64'd2, 64});
        tbl.push_back('{3'b101, 64'h1234, 64'd0, 6'd2, ONES, 0});
        tbl.push_back('{3'b111, 64'h1234, 64'd0, 6'd2, 64'h1234, 0});
        tbl.push_back('{3'b100, MINV, ONES, 6'd8, MINV, 0});
        tbl.push_back('{3'b110, MINV, ONES, 6'd8, 64'd0, 0});
        tbl.push_back('{3'b001, 64'd9, 64'd9, 6'd3, 64'd0, 0});
        tbl.push_back('{3'b101, 64'd100, 64'd7, 6'd31, 64'd14, 64});
        tbl.push_back('{3'b111, 64'd100, 64'd7, 6'd31, 64'd2, 64});
        tbl.push_back('{3'b000, 64'd6, 64'd7, 6'd0, 64'd42, 64});
        tbl.push_back('{3'b101, ONES, 64'd1, 6'd63, ONES, 64});

        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b,
                   tbl[i].rd, tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    f = 3'b000;
                2:       f = 3'b100;
                3:       f = 3'b101;
                4:       f = 3'b110;
                5:       f = 3'b111;
                default: f = 3'($urandom_range(0, 7));
            endcase
            a = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 1000));
                2:       b = -64'($urandom_range(1, 1000));
                3:       begin a = MINV; b = ONES; end
                default: b = {$urandom, $urandom};
            endcase
            rd = 6'($urandom_range(0, 63));
            run_op($sformatf("rnd%0d", i), f, a, b, rd,
                   model(f, a, b), model_lat(f, a, b));
        end

        // A start pulse while running must not disturb the latched op.
        funct3 = 3'b000;
        op_a   = 64'd3;
        op_b   = 64'd4;
        rd_in  = 6'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        funct3 = 3'b101;
        op_a   = 64'd55;
        op_b   = 64'd0;
        rd_in  = 6'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("ign busy", 64'(busy), 64'd1);
        chk("ign done", 64'(done), 64'd0);
        seen = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            seen = k + 1;
        end
        chk("ign seen", 64'(done), 64'd1);
        chk("ign lat", 64'(seen), 64'd54);
        chk("ign result", result, 64'd12);
        chk("ign rd", 64'(rd_out), 64'd7);
        tick();

        // Reset mid-operation aborts with no done.
        funct3 = 3'b000;
        op_a   = 64'd3;
        op_b   = 64'd4;
        rd_in  = 6'd9;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort result", result, 64'd0);
        chk("abort rd", 64'(rd_out), 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("abort quiet", 64'(seen), 64'd0);

        run_op("mul_rd0", 3'b000, 64'd3, 64'd4, 6'd0, 64'd12, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide execution unit sitting directly downstream of the register file. It takes the two source operands read from the register file together with the destination register index, and computes a product, quotient or remainder over multiple cycles. It returns the result with a write-enable ready to drive the register file write port (`wrt_data`, `rd`, `RegWrite`).

## Interface
- `XLEN`, 64, operand/result width; iteration count equals `XLEN`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE
- `funct3`  in  3  op select: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 unsupported
- `op_a`  in  XLEN  rs1 value (multiplicand / dividend)
- `op_b`  in  XLEN  rs2 value (multiplier / divisor)
- `rd_in`  in  6  destination register index
- `busy`  out  1  high from accept until return to IDLE
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  XLEN  computed value; held until next accepted start
- `rd_out`  out  6  latched `rd_in`
- `reg_write`  out  1  `done && rd_out != 0`

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on `start`, latch `funct3`, `op_a`, `op_b`, `rd_in`, clear iteration counter (7 bits), set `busy`.
  - Fast path to DONE, skipping RUN:
    - divisor zero: DIV/DIVU give all ones; REM/REMU give `op_a`.
    - DIV/REM with `op_a` = 0x8000_0000_0000_0000 and `op_b` = all ones: quotient is `op_a`, remainder is 0.
    - unsupported funct3: result 0.
  - Otherwise go to RUN.
- MUL: shift-add, one multiplier bit per cycle. Result is the low XLEN bits of the product; signedness is irrelevant to the low half.
- DIV/REM: restoring division on absolute values. Quotient is negated if operand signs differ; remainder takes the sign of the dividend.
- DIVU/REMU: unsigned restoring division.
- RUN: one iteration per cycle. After iteration `XLEN` (counter reaches 63 → wraps), go to DONE.
- DONE: `result` registered, `done` = 1 for exactly this cycle, then go to IDLE.
- `start` while busy (RUN or DONE) is ignored; latched operands are unaffected.
- `start` in IDLE during the same cycle as `done`: impossible, since DONE is not IDLE. The first possible restart is the cycle after `done`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `reg_write` 0, `result` 0, `rd_out` 0, counter 0.
- `rst` mid-operation aborts at the next edge. Same reset values apply, and no `done` is produced for the aborted operation.
- Normal op: `start` sampled at edge N. RUN iterations occur at edges N+1..N+64. `done`/`reg_write` are high during the cycle after edge N+64 and are sampled at edge N+65. `busy` falls at edge N+65.
- Fast path: `done` is high during the cycle after edge N, sampled at edge N+1; `busy` falls at edge N+1.
- Back-to-back: a new `start` can be accepted at edge N+65 (normal) or N+1 (fast).
- `result`/`rd_out` are stable from `done` until the next accepted `start`.
- `reg_write` is never high outside `done`, and never high for `rd_out` = 0.

## Test plan
- MUL, `op_a`=7, `op_b`=-3, `rd_in`=5 → `done` at edge N+65, `result`=0xFFFF_FFFF_FFFF_FFEB, `rd_out`=5, `reg_write`=1 for one cycle.
- DIV then REM of -20 by 3 → `result`=-6 (0xFFFF_FFFF_FFFF_FFFA), then -2 (0xFFFF_FFFF_FFFF_FFFE).
- DIVU by 0 with `op_a`=0x1234 → `done` at edge N+1, `result`=0xFFFF_FFFF_FFFF_FFFF. REMU by 0 → 0x1234.
- DIV overflow: 0x8000_0000_0000_0000 / all ones → 0x8000_0000_0000_0000; REM → 0; both fast path.
- MUL 3×4 started; `start` re-pulsed with other operands at cycle 10 (ignored); `rst` asserted at cycle 30 → `busy`/`done`/`result` = 0 next edge. New MUL 3×4 with `rd_in`=0 → `result`=12, `reg_write`=0.
- MULH (`funct3`=001) → fast-path `done`, `result`=0.
